// File: rtl/jk_bank_sequencer.sv
// Command sequencer that drives the J/K inputs of an external bank of JK flip-flops.
// Each step is one APPLY cycle (J/K driven) followed by one GAP cycle (Q settles).
module jk_bank_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_rpt,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_LOAD   = 3'b100;
    localparam logic [2:0] OP_CNT_UP = 3'b101;
    localparam logic [2:0] OP_CNT_DN = 3'b110;
    localparam logic [2:0] OP_ERR    = 3'b111;

    localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);

    // Returns {J, K} for one step of the given op against the current bank Q.
    function automatic logic [2*WIDTH-1:0] jk_drive(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] mask,
        input logic [WIDTH-1:0] data,
        input logic [WIDTH-1:0] q
    );
        logic [WIDTH-1:0] t_up;
        logic [WIDTH-1:0] t_dn;
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & q[i-1];
            t_dn[i] = t_dn[i-1] & ~q[i-1];
        end
        j = '0;
        k = '0;
        case (op)
            OP_CLEAR:  k = mask;
            OP_SET:    j = mask;
            OP_LOAD:   begin j = mask & data; k = mask & ~data; end
            OP_TOGGLE: begin j = mask; k = mask; end
            OP_CNT_UP: begin j = t_up & mask; k = t_up & mask; end
            OP_CNT_DN: begin j = t_dn & mask; k = t_dn & mask; end
            default:   begin j = '0; k = '0; end
        endcase
        return {j, k};
    endfunction

    logic [1:0]       state_q,   state_d;
    logic [2:0]       op_q,      op_d;
    logic [WIDTH-1:0] mask_q,    mask_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic [CNT_W:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0] j_q,       j_d;
    logic [WIDTH-1:0] k_q,       k_d;
    logic             done_q,    done_d;
    logic             aborted_q, aborted_d;
    logic             err_q,     err_d;

    logic [2*WIDTH-1:0] jk_cmd;
    logic [2*WIDTH-1:0] jk_rep;
    logic               multi_step;

    assign jk_cmd     = jk_drive(cmd_op, cmd_mask, cmd_data, q_in);
    assign jk_rep     = jk_drive(op_q, mask_q, data_q, q_in);
    assign multi_step = (cmd_op == OP_TOGGLE) || (cmd_op == OP_CNT_UP) || (cmd_op == OP_CNT_DN);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        mask_d    = mask_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        j_d       = '0;
        k_d       = '0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_op == OP_NOP) || (cmd_op == OP_ERR)) begin
                        done_d = 1'b1;
                        err_d  = (cmd_op == OP_ERR);
                    end else begin
                        state_d    = S_APPLY;
                        op_d       = cmd_op;
                        mask_d     = cmd_mask;
                        data_d     = cmd_data;
                        {j_d, k_d} = jk_cmd;
                        cnt_d      = multi_step ? ({1'b0, cmd_rpt} + CNT_ONE) : CNT_ONE;
                    end
                end
            end
            S_APPLY: begin
                // An abort here still lets the bank capture this step's J/K at the same edge.
                state_d = abort ? S_IDLE : S_GAP;
                if (abort) begin
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end else if (cnt_q > CNT_ONE) begin
                    state_d    = S_APPLY;
                    cnt_d      = cnt_q - CNT_ONE;
                    {j_d, k_d} = jk_rep;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            mask_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            j_q       <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mask_q    <= mask_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            j_q       <= j_d;
            k_q       <= k_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_APPLY) || (state_q == S_GAP);
    assign j_out     = j_q;
    assign k_out     = k_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign err       = err_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer driving an 8-bit JK flip-flop bank model.
// Latencies are counted in clock edges after the accepting edge E0.
module tb_jk_bank_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_mask;
    logic [7:0] cmd_data;
    logic [7:0] cmd_rpt;
    logic [7:0] q_in;
    logic [7:0] j_out;
    logic [7:0] k_out;
    logic       abort;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       err;

    logic [7:0] bank_q;
    logic       preset_en;
    logic [7:0] preset_val;

    int checks   = 0;
    int failures = 0;

    jk_bank_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_data  (cmd_data),
        .cmd_rpt   (cmd_rpt),
        .q_in      (q_in),
        .j_out     (j_out),
        .k_out     (k_out),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .err       (err)
    );

    always #5 clk = ~clk;

    // JK bank: Q+ = J&~Q | ~K&Q, with a bench-side preset path.
    always @(posedge clk) begin
        if (preset_en) bank_q <= preset_val;
        else           bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
    end
    assign q_in = bank_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preset(input logic [7:0] v);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    // Offers a command at a negedge; returns at the negedge after the accepting edge E0.
    task automatic issue(input logic [2:0] op, input logic [7:0] mask, input logic [7:0] data,
                         input logic [7:0] rpt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_data  = data;
        cmd_rpt   = rpt;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_mask  = 8'h00;
        cmd_data  = 8'h00;
        cmd_rpt   = 8'h00;
    endtask

    // Counts edges until done is seen (bounded); lat is 600 on timeout.
    task automatic wait_done(output int lat, output logic err_seen);
        lat = 0;
        while (!done && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        err_seen = err;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] mask;
        logic [7:0] data;
        logic [7:0] rpt;
        logic [7:0] q0;
        logic [7:0] exp_j;
        logic [7:0] exp_k;
        logic [7:0] exp_q;
        int         exp_lat;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int   lat;
        logic e;
        logic seen;

        vecs[0] = '{3'b010, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h0F, 2,   1'b0};
        vecs[1] = '{3'b100, 8'hFF, 8'hA5, 8'h00, 8'h3C, 8'hA5, 8'h5A, 8'hA5, 2,   1'b0};
        vecs[2] = '{3'b001, 8'hF0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hF0, 8'h0F, 2,   1'b0};
        vecs[3] = '{3'b001, 8'h81, 8'h00, 8'h07, 8'hFF, 8'h00, 8'h81, 8'h7E, 2,   1'b0};
        vecs[4] = '{3'b011, 8'h33, 8'h00, 8'h02, 8'h0F, 8'h33, 8'h33, 8'h3C, 6,   1'b0};
        vecs[5] = '{3'b000, 8'hFF, 8'hFF, 8'h05, 8'h55, 8'h00, 8'h00, 8'h55, 0,   1'b0};
        vecs[6] = '{3'b111, 8'hFF, 8'hFF, 8'h05, 8'hAA, 8'h00, 8'h00, 8'hAA, 0,   1'b1};
        vecs[7] = '{3'b100, 8'h0F, 8'hFF, 8'h03, 8'h00, 8'h0F, 8'h00, 8'h0F, 2,   1'b0};
        vecs[8] = '{3'b101, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h00, 2,   1'b0};
        vecs[9] = '{3'b110, 8'hFF, 8'h00, 8'h01, 8'h10, 8'h1F, 8'h1F, 8'h0E, 4,   1'b0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_mask = 8'h00;
        cmd_data = 8'h00; cmd_rpt = 8'h00; abort = 1'b0; preset_en = 1'b0; preset_val = 8'h00;
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_j", j_out, 0);
        check("rst_k", k_out, 0);
        check("rst_status", {done, aborted, err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            preset(vecs[i].q0);
            issue(vecs[i].op, vecs[i].mask, vecs[i].data, vecs[i].rpt);
            check($sformatf("v%0d_j", i), j_out, vecs[i].exp_j);
            check($sformatf("v%0d_k", i), k_out, vecs[i].exp_k);
            wait_done(lat, e);
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_err", i), e, vecs[i].exp_err);
            check($sformatf("v%0d_q", i), bank_q, vecs[i].exp_q);
        end

        // Full-range repeat count: 256 toggles leave bit 0 unchanged after 512 edges.
        preset(8'h00);
        issue(3'b011, 8'h01, 8'h00, 8'hFF);
        wait_done(lat, e);
        check("rpt_max_lat", lat, 512);
        check("rpt_max_q", bank_q, 8'h00);

        // COUNT_UP with wrap through all-ones.
        preset(8'hFE);
        issue(3'b101, 8'hFF, 8'h00, 8'h03);
        check("cup_j1", j_out, 8'h01);
        @(negedge clk); check("cup_q1", bank_q, 8'hFF); @(negedge clk);
        @(negedge clk); check("cup_q2", bank_q, 8'h00); @(negedge clk);
        @(negedge clk); check("cup_q3", bank_q, 8'h01); @(negedge clk);
        @(negedge clk); check("cup_q4", bank_q, 8'h02);
        check("cup_gap_jk", {j_out, k_out}, 0);
        check("cup_done_e7", done, 0);
        @(negedge clk);
        check("cup_done_e8", done, 1);

        // COUNT_DN aborted in the 3rd GAP.
        preset(8'h00);
        issue(3'b110, 8'hFF, 8'h00, 8'h09);
        repeat (5) @(negedge clk);
        check("cdn_busy_gap3", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("cdn_aborted", aborted, 1);
        check("cdn_no_done", done, 0);
        check("cdn_ready", cmd_ready, 1);
        check("cdn_q", bank_q, 8'hFD);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | done | aborted;
        end
        check("cdn_no_later_pulse", seen, 0);

        // Abort in APPLY: that step's J/K is still captured.
        preset(8'h00);
        issue(3'b011, 8'h0F, 8'h00, 8'h05);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abap_aborted", aborted, 1);
        check("abap_q", bank_q, 8'h0F);
        check("abap_ready", cmd_ready, 1);

        // abort alongside cmd_valid in IDLE: command is accepted.
        preset(8'h00);
        abort = 1'b1;
        issue(3'b010, 8'hF0, 8'h00, 8'h00);
        abort = 1'b0;
        check("idle_abort_busy", busy, 1);
        check("idle_abort_j", j_out, 8'hF0);
        check("idle_abort_noflag", aborted, 0);
        wait_done(lat, e);
        check("idle_abort_lat", lat, 2);
        check("idle_abort_q", bank_q, 8'hF0);

        // Back-to-back: next command accepted on the edge ending the done pulse.
        preset(8'h00);
        issue(3'b010, 8'h0F, 8'h00, 8'h00);
        wait_done(lat, e);
        check("b2b_lat1", lat, 2);
        check("b2b_ready_with_done", cmd_ready, 1);
        issue(3'b001, 8'h03, 8'h00, 8'h00);
        check("b2b_k", k_out, 8'h03);
        check("b2b_busy", busy, 1);
        wait_done(lat, e);
        check("b2b_lat2", lat, 2);
        check("b2b_q", bank_q, 8'h0C);

        // Asynchronous reset during COUNT_UP.
        preset(8'h00);
        issue(3'b101, 8'hFF, 8'h00, 8'd20);
        @(negedge clk);
        @(negedge clk);
        check("rcu_j_step2", j_out, 8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        check("rcu_j", j_out, 0);
        check("rcu_k", k_out, 0);
        check("rcu_busy", busy, 0);
        check("rcu_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | done | aborted | busy;
        end
        check("rcu_no_pulse", seen, 0);
        check("rcu_ready_after", cmd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
